// File: rtl/ctrl_pkg.sv
// Shared control encodings for the multi-cycle core: opcodes, FSM states and
// datapath mux selects (imm_sel is also consumed by the immediate generator).
package ctrl_pkg;

   localparam int unsigned OPC_W     = 7;
   localparam int unsigned PC_SEL_W  = 2;
   localparam int unsigned WB_SEL_W  = 2;
   localparam int unsigned IMM_SEL_W = 3;

   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [PC_SEL_W-1:0] PC_SEL_PLUS4  = 2'd0;
   localparam logic [PC_SEL_W-1:0] PC_SEL_TARGET = 2'd1;
   localparam logic [PC_SEL_W-1:0] PC_SEL_JALR   = 2'd2;

   localparam logic [WB_SEL_W-1:0] WB_SEL_ALU = 2'd0;
   localparam logic [WB_SEL_W-1:0] WB_SEL_MEM = 2'd1;
   localparam logic [WB_SEL_W-1:0] WB_SEL_PC4 = 2'd2;

   typedef enum logic [IMM_SEL_W-1:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_sel_t;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      CLS_R, CLS_OP_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
      CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_SYSTEM, CLS_ILLEGAL
   } op_class_t;

   typedef struct packed {
      op_class_t cls;
      imm_sel_t  imm_sel;
      logic      alu_src_b;
   } dec_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: instruction class, immediate format and
// ALU operand-B source.
module opcode_decoder
   import ctrl_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   output dec_t             dec_c
);

   always_comb begin
      dec_c.cls       = CLS_ILLEGAL;
      dec_c.imm_sel   = IMM_I;
      dec_c.alu_src_b = 1'b1;
      case (opcode)
         OPC_OP:     begin dec_c.cls = CLS_R;      dec_c.alu_src_b = 1'b0; end
         OPC_OP_IMM: dec_c.cls = CLS_OP_IMM;
         OPC_LOAD:   dec_c.cls = CLS_LOAD;
         OPC_STORE:  begin dec_c.cls = CLS_STORE;  dec_c.imm_sel = IMM_S; end
         OPC_BRANCH: begin
            dec_c.cls       = CLS_BRANCH;
            dec_c.imm_sel   = IMM_B;
            dec_c.alu_src_b = 1'b0;
         end
         OPC_JAL:    begin dec_c.cls = CLS_JAL;    dec_c.imm_sel = IMM_J; end
         OPC_JALR:   dec_c.cls = CLS_JALR;
         OPC_LUI:    begin dec_c.cls = CLS_LUI;    dec_c.imm_sel = IMM_U; end
         OPC_AUIPC:  begin dec_c.cls = CLS_AUIPC;  dec_c.imm_sel = IMM_U; end
         OPC_SYSTEM: dec_c.cls = CLS_SYSTEM;
         default:    dec_c.cls = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle core control FSM with memory handshake and retire counter.
// Build option: ILLEGAL_OPCODE_TRAP_EN halts on unrecognised opcodes.
module mc_control_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         instr,
   input  logic                 mem_ready,
   input  logic                 branch_taken,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic                 rf_we,
   output logic [PC_SEL_W-1:0]  pc_sel,
   output logic [IMM_SEL_W-1:0] imm_sel,
   output logic                 alu_src_b,
   output logic [WB_SEL_W-1:0]  wb_sel,
   output logic                 halt,
   output logic [N-1:0]         retired
);

   state_t state, state_nxt;
   dec_t   dec_c;
   logic   retire_c;
   logic   unused_instr;

   assign unused_instr = ^instr[N-1:OPC_W];

   opcode_decoder u_dec (
      .opcode (instr[OPC_W-1:0]),
      .dec_c  (dec_c)
   );

   // State register and retire counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_FETCH;
         retired <= '0;
      end else begin
         state <= state_nxt;
         if (retire_c) retired <= retired + N'(1);
      end
   end

   // Next state and control outputs
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      pc_sel    = PC_SEL_PLUS4;
      imm_sel   = IMM_I;
      alu_src_b = 1'b0;
      wb_sel    = WB_SEL_ALU;
      halt      = 1'b0;

      if (state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
         imm_sel   = dec_c.imm_sel;
         alu_src_b = dec_c.alu_src_b;
      end

      case (state)
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we     = 1'b1;
               pc_we     = 1'b1;
               state_nxt = ST_DECODE;
            end
         end
         ST_DECODE: state_nxt = ST_EXEC;
         ST_EXEC: begin
            case (dec_c.cls)
               CLS_R, CLS_OP_IMM, CLS_LUI, CLS_AUIPC: state_nxt = ST_WB;
               CLS_LOAD, CLS_STORE:                   state_nxt = ST_MEM;
               CLS_BRANCH: begin
                  pc_we     = branch_taken;
                  pc_sel    = PC_SEL_TARGET;
                  state_nxt = ST_FETCH;
               end
               CLS_JAL, CLS_JALR: begin
                  pc_we     = 1'b1;
                  pc_sel    = (dec_c.cls == CLS_JAL) ? PC_SEL_TARGET : PC_SEL_JALR;
                  rf_we     = 1'b1;
                  wb_sel    = WB_SEL_PC4;
                  state_nxt = ST_FETCH;
               end
               CLS_SYSTEM: state_nxt = ST_HALT;
`ifdef ILLEGAL_OPCODE_TRAP_EN
               default: state_nxt = ST_HALT;
`else
               default: state_nxt = ST_FETCH;
`endif
            endcase
         end
         ST_MEM: begin
            mem_req = 1'b1;
            mem_we  = (dec_c.cls == CLS_STORE);
            if (mem_ready) state_nxt = (dec_c.cls == CLS_STORE) ? ST_FETCH : ST_WB;
         end
         ST_WB: begin
            rf_we     = 1'b1;
            wb_sel    = (dec_c.cls == CLS_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
            state_nxt = ST_FETCH;
         end
         ST_HALT: halt = 1'b1;
         default: state_nxt = ST_FETCH;
      endcase

      // Reset abandons any access in flight, without waiting for a clock
      if (rst) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
         ir_we   = 1'b0;
         pc_we   = 1'b0;
         rf_we   = 1'b0;
      end
   end

   assign retire_c = (state_nxt == ST_FETCH) &&
                     (state inside {ST_EXEC, ST_MEM, ST_WB});

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-instruction-class cycle model,
// directed scenarios and randomized instruction streams with memory waits.
module tb_mc_control_fsm;

   localparam int N = 10;

   localparam int C_R = 0, C_IMM = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5,
                  C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_SYS = 9, C_ILL = 10;
   localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4, PH_H = 5;

`ifdef ILLEGAL_OPCODE_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       ir_we;
      logic       pc_we;
      logic       rf_we;
      logic [1:0] pc_sel;
      logic [2:0] imm_sel;
      logic       alu_src_b;
      logic [1:0] wb_sel;
      logic       halt;
   } outs_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] instr;
   logic         mem_ready;
   logic         branch_taken;
   logic         mem_req, mem_we, ir_we, pc_we, rf_we, alu_src_b, halt;
   logic [1:0]   pc_sel, wb_sel;
   logic [2:0]   imm_sel;
   logic [N-1:0] retired;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_ret = 0;
   logic       cap_pc_we;
   logic [1:0] cap_pc_sel, cap_wb_sel;
   logic [2:0] cap_imm;

   mc_control_fsm #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr        (instr),
      .mem_ready    (mem_ready),
      .branch_taken (branch_taken),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .rf_we        (rf_we),
      .pc_sel       (pc_sel),
      .imm_sel      (imm_sel),
      .alu_src_b    (alu_src_b),
      .wb_sel       (wb_sel),
      .halt         (halt),
      .retired      (retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int classify(input logic [6:0] op);
      case (op)
         7'b0110011: return C_R;
         7'b0010011: return C_IMM;
         7'b0000011: return C_LD;
         7'b0100011: return C_ST;
         7'b1100011: return C_BR;
         7'b1101111: return C_JAL;
         7'b1100111: return C_JALR;
         7'b0110111: return C_LUI;
         7'b0010111: return C_AUIPC;
         7'b1110011: return C_SYS;
         default:    return C_ILL;
      endcase
   endfunction

   function automatic logic [2:0] imm_fmt(input int c);
      case (c)
         C_ST:         return 3'd1;
         C_BR:         return 3'd2;
         C_LUI, C_AUIPC: return 3'd3;
         C_JAL:        return 3'd4;
         default:      return 3'd0;
      endcase
   endfunction

   // One clock: drive mem_ready, sample mid-cycle, compare against expectation
   task automatic cyc(input logic mr, input outs_t e, input int ph);
      outs_t a;
      mem_ready = mr;
      @(negedge clk);
      a = {mem_req, mem_we, ir_we, pc_we, rf_we, pc_sel, imm_sel, alu_src_b, wb_sel, halt};
      check($sformatf("outs ph%0d", ph), 32'(a), 32'(e));
      check("retired", 32'(retired), 32'(exp_ret));
      if (ph == PH_D) cap_imm = imm_sel;
      if (ph == PH_E) begin cap_pc_we = pc_we; cap_pc_sel = pc_sel; end
      if (ph == PH_W) cap_wb_sel = wb_sel;
      @(posedge clk);
      #1;
   endtask

   function automatic logic noise();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected per-cycle behaviour of one instruction, from FETCH entry onward
   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic bt);
      outs_t e, base;
      int    c;
      c = classify(ins[6:0]);
      instr = N'(ins);
      branch_taken = bt;
      base = '0;
      base.imm_sel = imm_fmt(c);
      base.alu_src_b = !(c == C_R || c == C_BR);
      for (int i = 0; i < fw; i++) begin
         e = '0; e.mem_req = 1'b1; cyc(1'b0, e, PH_F);
      end
      e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
      cyc(1'b1, e, PH_F);
      cyc(noise(), base, PH_D);
      e = base;
      case (c)
         C_BR:   begin e.pc_we = bt; e.pc_sel = 2'd1; end
         C_JAL:  begin e.pc_we = 1'b1; e.pc_sel = 2'd1; e.rf_we = 1'b1; e.wb_sel = 2'd2; end
         C_JALR: begin e.pc_we = 1'b1; e.pc_sel = 2'd2; e.rf_we = 1'b1; e.wb_sel = 2'd2; end
         default: ;
      endcase
      cyc(noise(), e, PH_E);
      if (c == C_LD || c == C_ST) begin
         e = base; e.mem_req = 1'b1; e.mem_we = (c == C_ST);
         for (int i = 0; i < mw; i++) cyc(1'b0, e, PH_M);
         cyc(1'b1, e, PH_M);
      end
      if (c inside {C_R, C_IMM, C_LUI, C_AUIPC, C_LD}) begin
         e = base; e.rf_we = 1'b1; e.wb_sel = (c == C_LD) ? 2'd1 : 2'd0;
         cyc(noise(), e, PH_W);
      end
      if (c == C_SYS || (c == C_ILL && TRAP)) begin
         e = '0; e.halt = 1'b1;
         for (int i = 0; i < 4; i++) cyc(noise(), e, PH_H);
      end else begin
         exp_ret = (exp_ret + 1) % (1 << N);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_ret = 0;
   endtask

   initial begin
      logic [6:0]  ops [10];
      logic [31:0] r;
      int          nops;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
      nops = TRAP ? 9 : 10;

      rst = 1'b1; mem_ready = 1'b0; instr = '0; branch_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mem_ready = 1'b1;
      #1;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_ir_we", 32'(ir_we), 32'd0);
      check("rst_halt", 32'(halt), 32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_ret = 0;

      // ADDI
      run_instr(32'h00500093, 0, 0, 1'b0);
      check("addi_imm_sel", 32'(cap_imm), 32'd0);
      check("addi_retired", 32'(retired), 32'd1);
      // LW with two wait states in FETCH and MEM
      run_instr(32'h0000A103, 2, 2, 1'b0);
      check("lw_wb_sel", 32'(cap_wb_sel), 32'd1);
      // BEQ taken then not taken
      run_instr(32'h00208463, 0, 0, 1'b1);
      check("beq_t_pc_we", 32'(cap_pc_we), 32'd1);
      check("beq_t_pc_sel", 32'(cap_pc_sel), 32'd1);
      run_instr(32'h00208463, 0, 0, 1'b0);
      check("beq_nt_pc_we", 32'(cap_pc_we), 32'd0);
      run_instr(32'h008000EF, 1, 0, 1'b0);
      check("jal_pc_sel", 32'(cap_pc_sel), 32'd1);
      run_instr(32'h000080E7, 0, 0, 1'b0);
      check("jalr_pc_sel", 32'(cap_pc_sel), 32'd2);
      check("retired_6", 32'(retired), 32'd6);

      // SW interrupted by reset while waiting in MEM
      begin
         outs_t e;
         instr = N'(32'h0020A023);
         e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
         cyc(1'b1, e, PH_F);
         e = '0; e.imm_sel = 3'd1; e.alu_src_b = 1'b1;
         cyc(1'b0, e, PH_D);
         cyc(1'b0, e, PH_E);
         mem_ready = 1'b0;
         #2;
         check("sw_mem_req", 32'(mem_req), 32'd1);
         check("sw_mem_we", 32'(mem_we), 32'd1);
         rst = 1'b1;
         #1;
         check("rst_async_mem_req", 32'(mem_req), 32'd0);
         check("rst_async_mem_we", 32'(mem_we), 32'd0);
         check("rst_async_retired", 32'(retired), 32'd0);
         @(posedge clk);
         #1;
         mem_ready = 1'b1;
         @(negedge clk);
         check("rst_hold_ir_we", 32'(ir_we), 32'd0);
         @(posedge clk);
         #1;
         rst = 1'b0;
         exp_ret = 0;
      end
      run_instr(32'h00500093, 0, 0, 1'b0);
      check("post_rst_retired", 32'(retired), 32'd1);

      // Unrecognised opcode
      run_instr(32'h0000007F, 0, 0, 1'b0);
      check("ill_halt", 32'(halt), TRAP ? 32'd1 : 32'd0);
      check("ill_retired", 32'(retired), TRAP ? 32'd1 : 32'd2);
      do_reset();
      // ECALL halts
      run_instr(32'h00000073, 0, 0, 1'b0);
      check("ecall_halt", 32'(halt), 32'd1);
      check("ecall_retired", 32'(retired), 32'd0);
      do_reset();

      // Randomized instruction stream with memory waits
      for (int k = 0; k < 1100; k++) begin
         int fw, mw;
         r = $urandom;
         fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         mw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_instr({r[31:7], ops[$urandom_range(0, nops - 1)]}, fw, mw, r[0]);
      end

      // Retire counter wrap
      do_reset();
      for (int k = 0; k < (1 << N) - 1; k++) run_instr(32'h000000B7, 0, 0, 1'b0);
      check("wrap_max", 32'(retired), 32'h3FF);
      run_instr(32'h000000B7, 0, 0, 1'b0);
      check("wrap_zero", 32'(retired), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
